i2c_slv_rx_core: RTL and testbench

- Synthesizable I2C target (responder) core: the receiving end of the 7-bit-address I2C write streams the bench-side I2C master drives.
- Sits behind the SoC pads (scl/sda, open-drain via output enable). Delivers received bytes through a small FIFO over valid/ready and serves master reads from a tx valid/ready stream.
- Raises a level interrupt while received data is pending.

---
 rtl/i2c_slv_rx_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_slv_rx_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slv_rx_core.sv
// I2C target core: 7-bit addressed writes land in an rx FIFO, master reads are served from a
// tx valid/ready stream. SDA is driven open-drain through sda_oe_o.
module i2c_slv_rx_core #(
  parameter logic [6:0]  SLV_ADDR    = 7'h50,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic       en_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       unf_o,
  input  logic       clr_flags_i,
  output logic       irq_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        oe_q, oe_d;
  logic        push_q, push_d;
  logic        rd_ack_q, rd_ack_d;
  logic        tx_ready_q, tx_ready_d;
  logic        ovf_q, unf_q, ovf_set, unf_set;
  logic        ld;
  logic        fifo_we, pop, full, empty;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, rptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q == {~rptr_q[PtrW], rptr_q[PtrW-1:0]});
  assign pop   = ~empty & rx_ready_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    push_d     = 1'b0;
    rd_ack_d   = rd_ack_q;
    tx_ready_d = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    fifo_we    = 1'b0;
    ld         = 1'b0;

    unique case (state_q)
      StAddr: begin
        if (scl_rise && cnt_q < 4'd8) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
        end else if (scl_fall && cnt_q == 4'd8) begin
          if (shift_q[7:1] == SLV_ADDR && en_i) begin
            state_d = StAddrAck;
            oe_d    = 1'b1;
          end else begin
            state_d = StIgnore;
          end
        end
      end
      StAddrAck: begin
        if (scl_fall) begin
          oe_d  = 1'b0;
          cnt_d = 4'd0;
          if (shift_q[0]) begin
            state_d = StRdData;
            ld      = 1'b1;
          end else begin
            state_d = StWrData;
          end
        end
      end
      StWrData: begin
        // The push lands one clk after the 8th rising edge, well before the next falling edge.
        if (push_q) begin
          if (full && !pop) begin
            ovf_set = 1'b1;
            state_d = StIgnore;
          end else begin
            fifo_we = 1'b1;
          end
        end else if (scl_rise && cnt_q < 4'd8) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
          push_d  = (cnt_q == 4'd7);
        end else if (scl_fall && cnt_q == 4'd8) begin
          state_d = StWrAck;
          oe_d    = 1'b1;
        end
      end
      StWrAck: begin
        if (scl_fall) begin
          oe_d    = 1'b0;
          cnt_d   = 4'd0;
          state_d = StWrData;
        end
      end
      StRdData: begin
        if (scl_fall) begin
          if (cnt_q == 4'd7) begin
            oe_d     = 1'b0;
            rd_ack_d = 1'b0;
            state_d  = StRdAck;
          end else begin
            shift_d = {shift_q[6:0], 1'b1};
            cnt_d   = cnt_q + 4'd1;
            oe_d    = ~shift_q[6];
          end
        end
      end
      StRdAck: begin
        if (scl_rise) begin
          if (sda_s) state_d = StIgnore;
          else       rd_ack_d = 1'b1;
        end else if (scl_fall && rd_ack_q) begin
          state_d = StRdData;
          ld      = 1'b1;
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      oe_d     = 1'b0;
      push_d   = 1'b0;
      rd_ack_d = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      push_d  = 1'b0;
    end

    if (!en_i) begin
      oe_d = 1'b0;
      if (state_d != StIdle) state_d = StIgnore;
    end

    // Only consume a tx byte if the load survives the bus/enable overrides above.
    if (ld && state_d == StRdData) begin
      cnt_d = 4'd0;
      if (tx_valid_i) begin
        shift_d    = tx_data_i;
        tx_ready_d = 1'b1;
        oe_d       = ~tx_data_i[7];
      end else begin
        shift_d = 8'hFF;
        unf_set = 1'b1;
        oe_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      oe_q       <= 1'b0;
      push_q     <= 1'b0;
      rd_ack_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      push_q     <= push_d;
      rd_ack_q   <= rd_ack_d;
      tx_ready_q <= tx_ready_d;
      ovf_q      <= ovf_set | (ovf_q & ~clr_flags_i);
      unf_q      <= unf_set | (unf_q & ~clr_flags_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (fifo_we) begin
        mem_q[wptr_q[PtrW-1:0]] <= shift_q;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign sda_oe_o   = oe_q & en_i;
  assign rx_data_o  = mem_q[rptr_q[PtrW-1:0]];
  assign rx_valid_o = ~empty;
  assign irq_o      = ~empty;
  assign tx_ready_o = tx_ready_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;
  assign busy_o     = (state_q == StAddrAck) || (state_q == StWrData) || (state_q == StWrAck) ||
                      (state_q == StRdData) || (state_q == StRdAck);

endmodule

// File: tb/tb_i2c_slv_rx_core.sv
// Bench: bit-banged I2C master with an open-drain bus model, checked against queue-based models.
module tb_i2c_slv_rx_core;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_oe_o, en_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready_i = 1'b0;
  logic [7:0] tx_data_i = 8'd0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o, busy_o, ovf_o, unf_o, irq_o;
  logic       clr_flags_i = 1'b0;
  logic       sda_bus;

  int nvec = 0, nerr = 0;
  int tx_pulses = 0;
  bit oe_seen = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign sda_bus = sda_m & ~sda_oe_o;

  i2c_slv_rx_core dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(sda_oe_o),
    .en_i(en_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .busy_o(busy_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .clr_flags_i(clr_flags_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Stream monitors and tx source, all on the edge opposite to the DUT's.
  always @(negedge clk_i) begin
    if (rx_valid_o && rx_ready_i) rx_q.push_back(rx_data_o);
    if (sda_oe_o) oe_seen = 1;
    if (tx_ready_o) begin
      tx_pulses++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    tx_valid_i = (tx_q.size() > 0);
    tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  task automatic cw(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; cw(5);
    sda_m = 1'b0; cw(5);
    scl_m = 1'b0; cw(5);
  endtask

  task automatic i2c_rep_start();
    sda_m = 1'b1; cw(5);
    scl_m = 1'b1; cw(5);
    sda_m = 1'b0; cw(5);
    scl_m = 1'b0; cw(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cw(5);
    scl_m = 1'b1; cw(5);
    sda_m = 1'b1; cw(5);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; cw(5);
    scl_m = 1'b1; cw(5);
    s = sda_bus; cw(5);
    scl_m = 1'b0; cw(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack_m, s);
  endtask

  task automatic test_reset();
    cw(4);
    nvec++; if (sda_oe_o !== 1'b0) begin nerr++; $display("FAIL reset_oe: got %b want 0", sda_oe_o); end
    nvec++; if (rx_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_rxv: got %b want 0", rx_valid_o); end
    nvec++; if (rx_data_o !== 8'h00) begin nerr++; $display("FAIL reset_rxd: got %h want 00", rx_data_o); end
    nvec++; if ({tx_ready_o, busy_o, ovf_o, unf_o, irq_o} !== 5'b0) begin
      nerr++; $display("FAIL reset_flags: got %b want 00000", {tx_ready_o, busy_o, ovf_o, unf_o, irq_o});
    end
    rst_ni = 1'b1;
    cw(5);
  endtask

  task automatic test_write();
    logic a;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    rx_ready_i = 1'b1; rx_q.delete();
    i2c_start();
    write_byte(8'hA0, a);
    nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL wr_addr_ack: got %b want 1", a); end
    nvec++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL wr_busy: got %b want 1", busy_o); end
    for (int i = 0; i < 3; i++) begin
      write_byte(exp[i], a);
      nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL wr_data_ack%0d: got %b want 1", i, a); end
    end
    i2c_stop(); cw(10);
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL wr_busy_end: got %b want 0", busy_o); end
    nvec++; if (irq_o !== 1'b0) begin nerr++; $display("FAIL wr_irq_end: got %b want 0", irq_o); end
    nvec++; if (rx_q.size() != 3) begin nerr++; $display("FAIL wr_count: got %0d want 3", rx_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      nvec++; if (rx_q[i] !== exp[i]) begin nerr++; $display("FAIL wr_byte%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_mismatch();
    logic a;
    logic [7:0] d;
    rx_ready_i = 1'b1; rx_q.delete(); oe_seen = 0;
    i2c_start();
    write_byte(8'hA2, a);
    nvec++; if (a !== 1'b0) begin nerr++; $display("FAIL mm_addr_ack: got %b want 0", a); end
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL mm_busy: got %b want 0", busy_o); end
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      write_byte(d, a);
      nvec++; if (a !== 1'b0) begin nerr++; $display("FAIL mm_data_ack%0d: got %b want 0", i, a); end
    end
    i2c_stop(); cw(10);
    nvec++; if (oe_seen !== 1'b0) begin nerr++; $display("FAIL mm_oe: got %b want 0", oe_seen); end
    nvec++; if (rx_q.size() != 0 || rx_valid_o !== 1'b0) begin
      nerr++; $display("FAIL mm_rx: got %0d bytes valid=%b want 0", rx_q.size(), rx_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic a, exp_a;
    int level = 0;
    bit ignored = 0;
    rx_ready_i = 1'b0; rx_q.delete();
    i2c_start();
    write_byte(8'hA0, a);
    nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL ovf_addr_ack: got %b want 1", a); end
    for (int i = 1; i <= 6; i++) begin
      if (ignored) exp_a = 1'b0;
      else if (level < 4) begin exp_a = 1'b1; level++; end
      else begin exp_a = 1'b0; ignored = 1; end
      write_byte(8'(i), a);
      nvec++; if (a !== exp_a) begin nerr++; $display("FAIL ovf_ack%0d: got %b want %b", i, a, exp_a); end
    end
    i2c_stop(); cw(5);
    nvec++; if (ovf_o !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b want 1", ovf_o); end
    clr_flags_i = 1'b1; cw(1); clr_flags_i = 1'b0; cw(1);
    nvec++; if (ovf_o !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", ovf_o); end
    rx_ready_i = 1'b1; cw(10);
    nvec++; if (rx_q.size() != level) begin nerr++; $display("FAIL ovf_count: got %0d want %0d", rx_q.size(), level); end
    else for (int i = 0; i < level; i++) begin
      nvec++; if (rx_q[i] !== 8'(i + 1)) begin nerr++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1)); end
    end
  endtask

  // Reads n bytes (master ACKs all but the last) from a freshly queued tx stream.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] bytes [$], input bit expect_hit,
                         input string tag);
    logic a;
    logic [7:0] got, want;
    tx_q = bytes; tx_pulses = 0; cw(2);
    i2c_start();
    write_byte(addr, a);
    nvec++; if (a !== expect_hit) begin nerr++; $display("FAIL %s_addr_ack: got %b want %b", tag, a, expect_hit); end
    for (int i = 0; i < bytes.size(); i++) begin
      read_byte(i != bytes.size() - 1, got);
      want = expect_hit ? bytes[i] : 8'hFF;
      nvec++; if (got !== want) begin nerr++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, got, want); end
    end
    i2c_stop(); cw(5);
    nvec++; if (tx_pulses != (expect_hit ? bytes.size() : 0)) begin
      nerr++; $display("FAIL %s_pulses: got %0d want %0d", tag, tx_pulses, expect_hit ? bytes.size() : 0);
    end
    tx_q.delete();
  endtask

  task automatic test_read();
    logic [7:0] b[$];
    b = '{8'h5A, 8'hC3};
    do_read(8'hA1, b, 1'b1, "rd");
    nvec++; if (unf_o !== 1'b0) begin nerr++; $display("FAIL rd_unf: got %b want 0", unf_o); end
  endtask

  task automatic test_underflow();
    logic a;
    logic [7:0] got;
    tx_q.delete(); tx_pulses = 0; cw(2);
    i2c_start();
    write_byte(8'hA1, a);
    nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL unf_addr_ack: got %b want 1", a); end
    read_byte(1'b0, got);
    i2c_stop(); cw(5);
    nvec++; if (got !== 8'hFF) begin nerr++; $display("FAIL unf_byte: got %h want ff", got); end
    nvec++; if (unf_o !== 1'b1) begin nerr++; $display("FAIL unf_flag: got %b want 1", unf_o); end
    nvec++; if (tx_pulses != 0) begin nerr++; $display("FAIL unf_pulses: got %0d want 0", tx_pulses); end
    clr_flags_i = 1'b1; cw(1); clr_flags_i = 1'b0; cw(1);
    nvec++; if (unf_o !== 1'b0) begin nerr++; $display("FAIL unf_clear: got %b want 0", unf_o); end
  endtask

  task automatic test_random();
    logic a;
    logic [6:0] a7;
    logic [7:0] b[$];
    bit hit;
    int n;
    rx_ready_i = 1'b1;
    for (int t = 0; t < 8; t++) begin
      hit = ($urandom_range(0, 3) != 0);
      a7 = hit ? 7'h50 : 7'($urandom_range(0, 126));
      if (!hit && a7 >= 7'h50) a7 = a7 + 7'd1;
      n = $urandom_range(1, 4);
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        do_read({a7, 1'b1}, b, hit, "rnd_rd");
      end else begin
        rx_q.delete();
        i2c_start();
        write_byte({a7, 1'b0}, a);
        nvec++; if (a !== hit) begin nerr++; $display("FAIL rnd_wr_addr_ack: got %b want %b", a, hit); end
        for (int i = 0; i < n; i++) begin
          write_byte(b[i], a);
          nvec++; if (a !== hit) begin nerr++; $display("FAIL rnd_wr_ack%0d: got %b want %b", i, a, hit); end
        end
        i2c_stop(); cw(10);
        nvec++; if (rx_q.size() != (hit ? n : 0)) begin
          nerr++; $display("FAIL rnd_wr_count: got %0d want %0d", rx_q.size(), hit ? n : 0);
        end else if (hit) for (int i = 0; i < n; i++) begin
          nvec++; if (rx_q[i] !== b[i]) begin nerr++; $display("FAIL rnd_wr_byte%0d: got %h want %h", i, rx_q[i], b[i]); end
        end
      end
    end
  endtask

  task automatic test_restart_reset();
    logic a, s;
    rx_ready_i = 1'b0; rx_q.delete();
    tx_q.delete(); tx_q.push_back(8'h00); cw(2);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h77, a);
    nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL rr_data_ack: got %b want 1", a); end
    i2c_rep_start();
    write_byte(8'hA1, a);
    nvec++; if (a !== 1'b1) begin nerr++; $display("FAIL rr_raddr_ack: got %b want 1", a); end
    nvec++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h77) begin
      nerr++; $display("FAIL rr_fifo: got valid=%b data=%h want 1/77", rx_valid_o, rx_data_o);
    end
    for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
    nvec++; if (sda_oe_o !== 1'b1) begin nerr++; $display("FAIL rr_driving: got %b want 1", sda_oe_o); end
    rst_ni = 1'b0;
    #1;
    nvec++; if (sda_oe_o !== 1'b0) begin nerr++; $display("FAIL rr_async_oe: got %b want 0", sda_oe_o); end
    cw(2);
    nvec++; if ({rx_valid_o, rx_data_o, tx_ready_o, busy_o, ovf_o, unf_o, irq_o} !== 14'b0) begin
      nerr++; $display("FAIL rr_reset_outs: got %b want 0", {rx_valid_o, rx_data_o, tx_ready_o, busy_o, ovf_o, unf_o, irq_o});
    end
    scl_m = 1'b1; sda_m = 1'b1; tx_q.delete(); cw(5);
    rst_ni = 1'b1; cw(5);
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_overflow();
    test_read();
    test_underflow();
    test_random();
    test_restart_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
